// File: rtl/parity_frame_tx.sv
// -----------------------------------------------------------------------------
// parity_frame_tx
//   Transmit side of the serial parity link. A parallel word is accepted over a
//   valid/ready handshake. It is sent one bit per transfer, and then one parity
//   bit follows. The serial side is a valid/ready stream toward the link/checker.
//
// Parameters
//   DATA_WIDTH : data bits per frame (>= 2)
//   ODD_PARITY : 0 = even parity over the frame, 1 = odd parity
//   LSB_FIRST  : 1 = bit 0 is sent first, 0 = bit DATA_WIDTH-1 is sent first
//
// Ports
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   in_data    in   parallel word to send
//   in_valid   in   in_data valid
//   in_ready   out  word accepted on an edge where in_valid && in_ready
//   out        out  serial bit (data or parity), 0 when out_valid is low
//   out_valid  out  out holds a valid bit
//   out_ready  in   sink accepts a bit on an edge where out_valid && out_ready
//   out_last   out  current bit is the parity bit (end of frame)
//   busy       out  frame in progress
// -----------------------------------------------------------------------------
module parity_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter bit ODD_PARITY = 1'b0,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_par;
    logic                  r_out;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_busy;

    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_first_bit;
    logic [DATA_WIDTH-1:0] w_shift_nx;
    logic                  w_next_bit;
    logic                  w_par_nx;

    // in_ready is combinational. In PARITY, a new word can only be taken on the
    // same edge the parity bit leaves, so there is no idle gap between frames.
    assign in_ready    = rstn && ((r_state == S_IDLE) ||
                                  ((r_state == S_PARITY) && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_xfer      = r_out_valid && out_ready;
    assign w_first_bit = LSB_FIRST ? in_data[0] : in_data[DATA_WIDTH-1];

    // The bit currently on 'out' is always at the send end of r_shift.
    assign w_shift_nx  = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
    assign w_next_bit  = LSB_FIRST ? w_shift_nx[0] : w_shift_nx[DATA_WIDTH-1];
    assign w_par_nx    = r_par ^ r_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_DATA;
                        r_shift     <= in_data;
                        r_cnt       <= '0;
                        r_par       <= 1'b0;
                        r_out       <= w_first_bit;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_xfer) begin
                        r_par   <= w_par_nx;
                        r_shift <= w_shift_nx;
                        if (r_cnt == LAST_IDX) begin
                            // The counter holds at its last index here. Only a
                            // new accept clears it.
                            r_state    <= S_PARITY;
                            r_out      <= w_par_nx ^ ODD_PARITY;
                            r_out_last <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_out <= w_next_bit;
                        end
                    end
                end

                S_PARITY: begin
                    if (w_xfer) begin
                        if (w_accept) begin
                            r_state     <= S_DATA;
                            r_shift     <= in_data;
                            r_cnt       <= '0;
                            r_par       <= 1'b0;
                            r_out       <= w_first_bit;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state     <= S_IDLE;
                            r_out       <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule
